// File: rtl/nibble_tx_pkg.sv
// nibble_tx_pkg: shared state encoding and frame constants for the nibble parity transmitter
package nibble_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam int FRAME_BITS = 7;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/nibble_tx_baud.sv
// nibble_tx_baud: bit-period counter that ticks on the last cycle of each serial bit
module nibble_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == LAST;
  assign cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  // count cycles within the current bit, held at 0 while idle so a frame starts aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/nibble_parity_tx.sv
// nibble_parity_tx: serialises a nibble plus its parity bit as start/data/parity/stop; PARITY_CHECK_EN adds a parity checker
module nibble_parity_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic paridade_par,
  input  logic in_valid,
  output logic in_ready,
  output logic tx_out,
  output logic busy,
  output logic frame_done,
  output logic parity_err
);
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] data_q, data_d;
  logic par_q, par_d;
  logic tick;
  logic accept;

  nibble_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q == S_IDLE),
    .tick  (tick)
  );

  assign in_ready   = state_q == S_IDLE;
  assign busy       = !in_ready;
  assign accept     = in_valid && in_ready;
  assign frame_done = (state_q == S_STOP) && tick;

  // next-state: capture on acceptance, advance one frame bit on each tick
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_START;
        data_d  = {I3, I2, I1, I0};
        par_d   = paridade_par;
      end
      S_START: if (tick) begin
        state_d = S_DATA;
        idx_d   = 2'd0;
      end
      S_DATA: if (tick) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_PARITY;
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // serial line is a pure decode of the registered state, so reset drives it idle immediately
  always_comb
    tx_out = (state_q == S_START)  ? 1'b0 :
             (state_q == S_DATA)   ? data_q[idx_q] :
             (state_q == S_PARITY) ? par_q : IDLE_LEVEL;

  // frame state and captured nibble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end

`ifdef PARITY_CHECK_EN
  logic perr_q, perr_d;
  assign perr_d     = accept ? ((I0 ^ I1 ^ I2 ^ I3) != paridade_par) : perr_q;
  assign parity_err = perr_q;
  // mismatch flag refreshed on every acceptance and held in between
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_parity_tx.sv
// tb_nibble_parity_tx: randomized directed checks of serial framing, handshake, reset abort and parity flag
module tb_nibble_parity_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  logic I0 = 1'b0, I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, par = 1'b0;
  logic va = 1'b0, vb = 1'b0;
  logic a_rdy, a_tx, a_busy, a_done, a_err;
  logic b_rdy, b_tx, b_busy, b_done, b_err;
  logic ea = 1'b0, eb = 1'b0;
  logic [3:0] rd;
  logic rp;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  nibble_parity_tx #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .paridade_par(par), .in_valid(va), .in_ready(a_rdy), .tx_out(a_tx),
    .busy(a_busy), .frame_done(a_done), .parity_err(a_err)
  );

  nibble_parity_tx #(.CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .paridade_par(par), .in_valid(vb), .in_ready(b_rdy), .tx_out(b_tx),
    .busy(b_busy), .frame_done(b_done), .parity_err(b_err)
  );

  function automatic logic err_of(input logic [3:0] d, input logic p);
    logic e;
    e = (^d) != p;
`ifndef PARITY_CHECK_EN
    e = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input bit sel, input string tag, input logic etx, input logic erdy,
                           input logic ebusy, input logic edone, input logic eerr);
    chk({tag, ".tx"},    sel ? b_tx   : a_tx,   etx);
    chk({tag, ".ready"}, sel ? b_rdy  : a_rdy,  erdy);
    chk({tag, ".busy"},  sel ? b_busy : a_busy, ebusy);
    chk({tag, ".done"},  sel ? b_done : a_done, edone);
    chk({tag, ".perr"},  sel ? b_err  : a_err,  eerr);
  endtask

  task automatic drive(input logic [3:0] d, input logic p);
    {I3, I2, I1, I0} = d;
    par = p;
  endtask

  task automatic frame(input bit sel, input logic [3:0] d, input logic p, input bit next_valid);
    int c;
    logic [6:0] bits;
    logic e;
    c = sel ? 1 : 4;
    check_all(sel, "idle", 1'b1, 1'b1, 1'b0, 1'b0, sel ? eb : ea);
    bits = {1'b1, p, d, 1'b0};
    e = err_of(d, p);
    if (sel) eb = e; else ea = e;
    drive(d, p);
    if (sel) vb = 1'b1; else va = 1'b1;
    for (int t = 1; t <= 7 * c; t++) begin
      @(negedge clk);
      check_all(sel, "frame", bits[(t - 1) / c], 1'b0, 1'b1, t == 7 * c, e);
      drive(4'($urandom), 1'($urandom));
      if (sel) vb = (t == 7 * c) ? next_valid : 1'($urandom);
      else     va = (t == 7 * c) ? next_valid : 1'($urandom);
    end
    @(negedge clk);
  endtask

  initial begin
    #1;
    check_all(1'b0, "rst_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all(1'b1, "rst_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(1'b0, 4'b1101, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) frame(1'b0, 4'(k), ^(4'(k)), 1'b0);
    frame(1'b0, 4'b0000, 1'b1, 1'b0);
    frame(1'b0, 4'b0000, 1'b0, 1'b0);
    rd = 4'($urandom); rp = 1'($urandom);
    frame(1'b0, rd, rp, 1'b1);
    rd = 4'($urandom); rp = 1'($urandom);
    frame(1'b0, rd, rp, 1'b0);
    check_all(1'b0, "abort_idle", 1'b1, 1'b1, 1'b0, 1'b0, ea);
    rd = 4'($urandom); rp = 1'($urandom);
    drive(rd, rp);
    va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    repeat (4 * 3) @(negedge clk);
    chk("abort.bit2", a_tx, rd[2]);
    chk("abort.busy_pre", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    ea = 1'b0;
    eb = 1'b0;
    check_all(1'b0, "abort_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check_all(1'b0, "post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (6) begin
      rd = 4'($urandom); rp = 1'($urandom);
      frame(1'b1, rd, rp, 1'b0);
    end
    rd = 4'($urandom); rp = 1'($urandom);
    frame(1'b1, rd, rp, 1'b1);
    rd = 4'($urandom); rp = 1'($urandom);
    frame(1'b1, rd, rp, 1'b0);
    repeat (4) begin
      rd = 4'($urandom); rp = 1'($urandom);
      frame(1'b0, rd, rp, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_parity_tx.md
NIBBLE_PARITY_TX -- requirements
Module: nibble_parity_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 4, clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: I0, I1, I2, I3  input  1 each  data nibble from the upstream even-parity generator.
REQ-005 SHALL have port: paridade_par  input  1  even-parity bit from the upstream generator.
REQ-006 SHALL have port: in_valid  input  1  nibble and parity are valid.
REQ-007 SHALL have port: in_ready  output  1  block can accept a nibble.
REQ-008 SHALL have port: tx_out  output  1  serial line, idle high.
REQ-009 SHALL have port: busy  output  1  frame in progress.
REQ-010 SHALL have port: frame_done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port: parity_err  output  1  parity mismatch flag (see Configuration).

Function
REQ-012 SHALL accept a nibble on a cycle with in_valid=1 and in_ready=1, registering I0..I3 and paridade_par.
REQ-013 SHALL drive in_ready=1 only in IDLE; it SHALL drop in the cycle after acceptance.
REQ-014 SHALL transmit a 7-bit frame: start(0), I0, I1, I2, I3, paridade_par, stop(1), in that order.
REQ-015 SHALL hold each frame bit on tx_out for exactly CLKS_PER_BIT cycles; a frame SHALL last 7*CLKS_PER_BIT cycles.
REQ-016 SHALL drive the start bit on tx_out starting in the cycle after acceptance (latency 1).
REQ-017 SHALL use states IDLE -> START -> DATA (4 bits, index 0..3) -> PARITY -> STOP -> IDLE; each transition SHALL occur on the last cycle of the current bit period.
REQ-018 SHALL assert busy in every state other than IDLE.
REQ-019 SHALL pulse frame_done for exactly one cycle in the last cycle of STOP.
REQ-020 SHALL spend at least one cycle in IDLE between frames; back-to-back frames SHALL have one idle-high cycle between stop and the next start.
REQ-021 SHALL ignore in_valid and input changes while busy; the registered nibble SHALL NOT change mid-frame.
REQ-022 SHALL use a bit-period counter of width $clog2(CLKS_PER_BIT+1) that wraps to 0 at CLKS_PER_BIT-1; for CLKS_PER_BIT=1 every cycle SHALL be a bit boundary.

Reset
REQ-023 SHALL, while rst_n=0, force the state to IDLE, tx_out=1, in_ready=1, busy=0, frame_done=0, parity_err=0, and counters and registered data to 0, asynchronously.
REQ-024 SHALL abort any frame in progress when reset asserts mid-frame; after release the line SHALL stay idle high until a new acceptance.

Configuration
REQ-025 SHALL, when PARITY_CHECK_EN is defined, compute I0^I1^I2^I3 at acceptance and set parity_err=1 from the next cycle if it differs from paridade_par, holding it until the next acceptance or reset.
REQ-026 SHALL transmit the received paridade_par unmodified regardless of parity_err.
REQ-027 SHALL, when PARITY_CHECK_EN is not defined, tie parity_err to 0 and omit the checker logic.

Structure
REQ-028 SHALL define the state enum, FRAME_BITS=7 and IDLE_LEVEL=1 in the shared package nibble_tx_pkg.
REQ-029 SHALL implement the bit-period counter as sub-module nibble_tx_baud (inputs clk, rst_n, clear; output tick).

Verification
REQ-030 SHALL check, with CLKS_PER_BIT=4, I3..I0=1101, paridade_par=1 and a single valid: tx_out = 0,1,0,1,1,1,1, each bit for 4 cycles; frame_done pulses at cycle 28 after acceptance.
REQ-031 SHALL check that all 16 nibble values with correct even parity give parity_err=0 and the correct serial bit order (PARITY_CHECK_EN defined).
REQ-032 SHALL check that nibble 0000 with paridade_par=1 gives parity_err=1 from acceptance+1, transmits parity bit 1, and clears on the next correct acceptance.
REQ-033 SHALL check that with in_valid held high for two frames, the second start bit follows exactly one idle-high cycle after stop, and in_ready is high only in that cycle.
REQ-034 SHALL check that rst_n asserted during DATA bit 2 immediately gives tx_out=1, busy=0 and in_ready=1, and that no frame_done follows.
REQ-035 SHALL check that with CLKS_PER_BIT=1 a frame lasts 7 cycles and that input changes while busy=1 do not alter the transmitted bits.
